// File: rtl/rx_timestamp_unit.sv
// Free-running {secs,nsecs} time-of-day counter with host load detect, plus a show-ahead
// FIFO of 64-bit timestamps captured on rx frame-start strobes.
module rx_timestamp_unit #(
  parameter int NS_PER_CLK = 4,
  parameter int NS_WRAP    = 1_000_000_000,
  parameter int FIFO_AW    = 4
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic [31:0] sys_nsecs,
  input  logic [31:0] sys_secs,
  input  logic        rx_timestamp_en,
  input  logic        rx_sof_strobe,
  output logic        ts_valid,
  output logic [63:0] ts_data,
  input  logic        ts_ready,
  output logic [31:0] cur_nsecs,
  output logic [31:0] cur_secs,
  output logic [15:0] ts_drop_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [31:0] prev_nsecs, prev_secs;
  logic        nload, sload, wrap;
  logic [31:0] nload_val;
  logic [32:0] sum, diff;

  assign nload     = sys_nsecs != prev_nsecs;
  assign sload     = sys_secs  != prev_secs;
  assign nload_val = (sys_nsecs >= 32'(NS_WRAP)) ? 32'd0 : sys_nsecs;
  assign sum       = {1'b0, cur_nsecs} + 33'(NS_PER_CLK);
  assign diff      = sum - 33'(NS_WRAP);
  // no borrow out of sum - NS_WRAP means sum >= NS_WRAP
  assign wrap      = !diff[32];

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      prev_nsecs <= '0;
      prev_secs  <= '0;
      cur_nsecs  <= '0;
      cur_secs   <= '0;
    end else begin
      prev_nsecs <= sys_nsecs;
      prev_secs  <= sys_secs;
      if (nload)      cur_nsecs <= nload_val;
      else if (wrap)  cur_nsecs <= diff[31:0];
      else            cur_nsecs <= sum[31:0];
      // a load on either field suppresses the carry into secs
      if (sload)              cur_secs <= sys_secs;
      else if (wrap && !nload) cur_secs <= cur_secs + 32'd1;
    end
  end

  logic [63:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [FIFO_AW:0]   count;
  logic               full, push_req, pop, push, drop;
  logic [63:0]        cap;

  assign cap       = {cur_secs, cur_nsecs};
  assign full      = count == (FIFO_AW+1)'(DEPTH);
  assign push_req  = rx_sof_strobe && rx_timestamp_en;
  assign pop       = ts_valid && ts_ready;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && !push;
  assign rd_ptr_nx = rd_ptr + 1'b1;

  always_ff @(posedge trn_clk) begin
    if (push) mem[wr_ptr] <= cap;
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ts_valid    <= 1'b0;
      ts_data     <= '0;
      ts_drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_nx;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // head register: next entry comes from memory, or straight from the
      // capture when the popped entry was the only one queued
      if (pop) begin
        if (count > (FIFO_AW+1)'(1)) begin
          ts_data <= mem[rd_ptr_nx];
        end else begin
          ts_valid <= push;
          if (push) ts_data <= cap;
        end
      end else if (push && !ts_valid) begin
        ts_valid <= 1'b1;
        ts_data  <= cap;
      end
      if (drop && ts_drop_cnt != 16'hFFFF) ts_drop_cnt <= ts_drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_rx_timestamp_unit.sv
// Directed table-driven bench for rx_timestamp_unit: counter load/wrap, capture, FIFO full/drop, reset flush.
module tb_rx_timestamp_unit;
  logic        trn_clk = 1'b0;
  logic        reset;
  logic [31:0] sys_nsecs, sys_secs;
  logic        rx_timestamp_en, rx_sof_strobe, ts_ready;
  logic        ts_valid;
  logic [63:0] ts_data;
  logic [31:0] cur_nsecs, cur_secs;
  logic [15:0] ts_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 trn_clk = ~trn_clk;

  rx_timestamp_unit dut (
    .trn_clk(trn_clk), .reset(reset), .sys_nsecs(sys_nsecs), .sys_secs(sys_secs),
    .rx_timestamp_en(rx_timestamp_en), .rx_sof_strobe(rx_sof_strobe),
    .ts_valid(ts_valid), .ts_data(ts_data), .ts_ready(ts_ready),
    .cur_nsecs(cur_nsecs), .cur_secs(cur_secs), .ts_drop_cnt(ts_drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ns, s;
    logic        st, rd, en;
    logic [31:0] e_ns, e_s;
    logic        e_v;
    logic [63:0] e_d;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vt [13];
  logic [63:0] prev_head;

  initial begin
    // drive one row, one clock, expected state after that edge
    vt[0]  = '{999_999_996, 7, 0, 0, 1, 999_999_996, 7, 0, 0, 0};
    vt[1]  = '{999_999_996, 7, 0, 0, 1, 0,           8, 0, 0, 0};
    vt[2]  = '{999_999_996, 7, 0, 0, 1, 4,           8, 0, 0, 0};
    vt[3]  = '{999_999_992, 7, 0, 0, 1, 999_999_992, 8, 0, 0, 0};
    vt[4]  = '{999_999_992, 7, 0, 0, 1, 999_999_996, 8, 0, 0, 0};
    vt[5]  = '{5,           7, 0, 0, 1, 5,           8, 0, 0, 0};
    vt[6]  = '{5,           7, 0, 0, 1, 9,           8, 0, 0, 0};
    vt[7]  = '{100,         7, 0, 0, 1, 100,         8, 0, 0, 0};
    vt[8]  = '{100,         7, 1, 0, 1, 104,         8, 1, {32'd8, 32'd100}, 0};
    vt[9]  = '{100,         7, 0, 1, 1, 108,         8, 0, 0, 0};
    vt[10] = '{100,         7, 1, 0, 0, 112,         8, 0, 0, 0};
    vt[11] = '{100,         7, 0, 0, 1, 116,         8, 0, 0, 0};
    vt[12] = '{1000,        7, 0, 0, 1, 1000,        8, 0, 0, 0};

    reset = 1'b1; sys_nsecs = 0; sys_secs = 0;
    rx_timestamp_en = 0; rx_sof_strobe = 0; ts_ready = 0;
    repeat (3) @(negedge trn_clk);
    chk("reset_nsecs", 64'(cur_nsecs), 0);
    chk("reset_valid", 64'(ts_valid), 0);
    chk("reset_data", ts_data, 0);
    reset = 1'b0;
    repeat (10) @(negedge trn_clk);
    chk("idle_nsecs", 64'(cur_nsecs), 40);
    chk("idle_secs", 64'(cur_secs), 0);
    chk("idle_valid", 64'(ts_valid), 0);
    chk("idle_drop", 64'(ts_drop_cnt), 0);

    for (int i = 0; i < 13; i++) begin
      sys_nsecs = vt[i].ns; sys_secs = vt[i].s; rx_sof_strobe = vt[i].st;
      ts_ready = vt[i].rd; rx_timestamp_en = vt[i].en;
      @(negedge trn_clk);
      chk($sformatf("v%0d_nsecs", i), 64'(cur_nsecs), 64'(vt[i].e_ns));
      chk($sformatf("v%0d_secs", i), 64'(cur_secs), 64'(vt[i].e_s));
      chk($sformatf("v%0d_valid", i), 64'(ts_valid), 64'(vt[i].e_v));
      if (vt[i].e_v) chk($sformatf("v%0d_data", i), ts_data, vt[i].e_d);
      chk($sformatf("v%0d_drop", i), 64'(ts_drop_cnt), 64'(vt[i].e_drop));
    end

    // 18 back-to-back strobes from cur=8/1000 fill 16 entries and drop 2;
    // a 19th strobe with a simultaneous pop is accepted while full
    for (int i = 0; i < 19; i++) begin
      rx_sof_strobe = 1'b1;
      ts_ready = (i == 18);
      @(negedge trn_clk);
      if (i == 17) begin
        chk("full_drop", 64'(ts_drop_cnt), 2);
        chk("full_head", ts_data, {32'd8, 32'd1000});
      end
    end
    rx_sof_strobe = 1'b0; ts_ready = 1'b0;
    chk("pushpop_drop", 64'(ts_drop_cnt), 2);
    chk("pushpop_valid", 64'(ts_valid), 1);
    chk("pushpop_head", ts_data, {32'd8, 32'd1004});
    chk("pushpop_nsecs", 64'(cur_nsecs), 1076);

    // entries stay poppable with capture disabled; drain in order
    rx_timestamp_en = 1'b0;
    prev_head = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_data", k), ts_data, {32'd8, 32'(1004 + 4 * k)});
      chk($sformatf("drain%0d_incr", k), 64'(ts_data > prev_head), 1);
      prev_head = ts_data;
      ts_ready = 1'b1;
      @(negedge trn_clk);
    end
    chk("drain_head", ts_data, {32'd8, 32'd1036});
    chk("drain_valid", 64'(ts_valid), 1);

    reset = 1'b1; ts_ready = 1'b0;
    @(negedge trn_clk);
    chk("flush_valid", 64'(ts_valid), 0);
    chk("flush_data", ts_data, 0);
    chk("flush_drop", 64'(ts_drop_cnt), 0);
    chk("flush_nsecs", 64'(cur_nsecs), 0);
    chk("flush_secs", 64'(cur_secs), 0);
    reset = 1'b0;
    @(negedge trn_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
